// File: rtl/lin_interp_if.sv
// Stream bundle for lin_interp: valid/ready sample input, valid-only sample output.
interface lin_interp_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             i_vld;
  logic [WIDTH-1:0] i_data;
  logic             o_rdy;
  logic             o_vld;
  logic [WIDTH-1:0] o_data;

  modport slave (
    input  i_vld,
    input  i_data,
    output o_rdy,
    output o_vld,
    output o_data
  );

  modport master (
    output i_vld,
    output i_data,
    input  o_rdy,
    input  o_vld,
    input  o_data
  );
endinterface

// File: rtl/lin_interp.sv
// Linear-interpolating upsampler: each accepted sample closes a segment of 2^N outputs
// stepping from the previous sample toward it with floor rounding.
module lin_interp #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  lin_interp_if.slave bus
);

  localparam int unsigned AW = WIDTH + N + 1;
  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned CW = (N > 0) ? N : 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]     prev_q, prev_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] diff_q, diff_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 o_vld_q, o_vld_d;
  logic [WIDTH-1:0]     o_data_q, o_data_d;

  logic                 seg_last;
  logic                 rdy;
  logic                 accept;
  logic signed [DW-1:0] diff_new;

  // The counter runs one ahead of the emitted index, so it wraps to zero on the last sample.
  assign seg_last = (N == 0) || (cnt_q == '0);
  assign accept   = bus.i_vld && rdy;
  assign diff_new = $signed({1'b0, bus.i_data}) - $signed({1'b0, prev_q});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = PRIMED;
      PRIMED:  if (accept) state_d = RUN;
      RUN:     if (seg_last && !accept) state_d = PRIMED;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rdy = 1'b1;
    case (state_q)
      EMPTY:   rdy = 1'b1;
      PRIMED:  rdy = 1'b1;
      RUN:     rdy = seg_last;
      default: rdy = 1'b1;
    endcase
  end

  // Datapath next values; an accept in PRIMED or RUN always starts a fresh segment at k=0.
  always_comb begin
    prev_d   = prev_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    o_vld_d  = 1'b0;
    o_data_d = o_data_q;
    case (state_q)
      EMPTY: begin
        if (accept) prev_d = bus.i_data;
      end
      PRIMED, RUN: begin
        if (accept) begin
          o_vld_d  = 1'b1;
          o_data_d = prev_q;
          diff_d   = diff_new;
          acc_d    = $signed(AW'(prev_q) << N) + $signed(AW'(diff_new));
          cnt_d    = CW'(1);
          prev_d   = bus.i_data;
        end else if (state_q == RUN && !seg_last) begin
          o_vld_d  = 1'b1;
          o_data_d = WIDTH'(acc_q >>> N);
          acc_d    = acc_q + AW'(diff_q);
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q   <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      o_vld_q  <= 1'b0;
      o_data_q <= '0;
    end else begin
      prev_q   <= prev_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      o_vld_q  <= o_vld_d;
      o_data_q <= o_data_d;
    end
  end

  assign bus.o_rdy  = rdy;
  assign bus.o_vld  = o_vld_q;
  assign bus.o_data = o_data_q;

endmodule
